chan_err_injector: RTL and testbench
====================================

// Module: chan_err_injector
// PURPOSE
//  Parametrised channel model between the convolutional encoder and Viterbi decoder.
//  Carries SYM_W-bit code symbols with 1-cycle latency and XOR-corrupts selected symbols.
//  Three corruption sources:
//   - periodic burst windows
//   - LFSR-driven random errors
//   - both combined
//  Keeps saturating statistics so benches can relate decoder BER to injected channel BER.
// PARAMETERS
//  SYM_W       2         bits per code symbol (code rate 1/SYM_W)
//  PERIOD_LOG2 5         burst period = 2**PERIOD_LOG2 valid symbols
//  LFSR_W      16        random-error LFSR width
//  LFSR_SEED   16'hACE1  LFSR reset/clear value, must be nonzero
//  CNT_W       16        width of statistics counters
// PORTS
//  clk                clk  1              rising-edge clock
//  rst                in   1              synchronous, active-high reset
//  cfg_mode_i         in   2              0 OFF, 1 BURST, 2 RANDOM, 3 BOTH
//  cfg_burst_start_i  in   PERIOD_LOG2    first corrupted phase in each period
//  cfg_burst_len_i    in   PERIOD_LOG2+1  corrupted symbols per period, 0..2**PERIOD_LOG2
//  cfg_err_mask_i     in   SYM_W          bits XORed into a hit symbol
//  cfg_rand_thresh_i  in   LFSR_W         random hit when lfsr <= thresh
//  cfg_sym_limit_i    in   CNT_W          injection only while sym_ct < limit; 0 = unlimited
//  clear_i            in   1              zero stats/index, reseed LFSR
//  valid_i            in   1              sym_i valid this cycle
//  sym_i              in   SYM_W          clean encoder symbol
//  valid_o            out  1              registered valid_i
//  sym_o              out  SYM_W          channel output symbol
//  err_o              out  1              sym_o was corrupted
//  active_o           out  1              injection window open (sym_ct < limit or limit == 0)
//  sym_ct_o           out  CNT_W          valid symbols seen
//  err_sym_ct_o       out  CNT_W          corrupted symbols
//  bad_bit_ct_o       out  CNT_W          flipped bits, sum of popcount(mask) over hits
// BEHAVIOUR
//  Reset: every output and counter is 0; active_o=1 for the cycle after reset; lfsr=LFSR_SEED.
//  Latency: exactly 1 cycle. valid_o(t+1)=valid_i(t); sym_o/err_o updated only when valid_i, else held.
//  Symbol index and phase:
//   - sym_idx counts valid_i symbols only; gaps do not advance it.
//   - phase = sym_idx[PERIOD_LOG2-1:0], wraps modulo period.
//   - LFSR (Galois, maximal-length) steps once per valid symbol, after use.
//  Burst hit: ((phase - cfg_burst_start_i) mod 2**PERIOD_LOG2) < cfg_burst_len_i.
//   - Window wraps across the period boundary.
//   - len=0 means never; len=2**PERIOD_LOG2 means every symbol.
//  Random hit: lfsr <= cfg_rand_thresh_i. Since lfsr is never 0: thresh=0 means never, all-ones means always.
//  Hit qualifiers:
//   - hit = active window AND (burst hit in modes 1,3 OR random hit in modes 2,3).
//   - Mode 0 never hits.
//   - A hit with cfg_err_mask_i=0 counts as an err symbol with 0 bad bits.
//  On a valid symbol:
//   - sym_o = sym_i ^ (hit ? mask : 0); err_o = hit.
//   - sym_ct+1; err_sym_ct+hit; bad_bit_ct+popcount(mask) on a hit.
//   - All counters saturate at all-ones and never wrap. sym_idx wraps freely.
//  Window: active_o evaluated on current sym_ct. Once closed it stays closed until clear or reset, unless limit is raised or set to 0.
//  Config inputs are sampled every cycle; a change applies to the next valid symbol.
//  clear_i precedence:
//   - clear_i has priority over valid_i.
//   - That cycle's symbol passes uncorrupted, valid_o still follows valid_i, and nothing is counted.
//   - sym_idx=0, lfsr=LFSR_SEED, all statistics 0.
//  rst mid-stream: everything returns to reset values next cycle; the in-flight symbol is dropped (valid_o=0).
// STRUCTURE
//  chan_err_pkg holds:
//   - err_mode_e enum: ERR_OFF, ERR_BURST, ERR_RANDOM, ERR_BOTH
//   - popcount function
//   - default LFSR tap constant (16'hB400 for LFSR_W=16)
//  Sub-module lfsr_gen #(W, SEED, TAPS): ports clk, rst, clear, step, value.
//  The top level holds the index counter, hit logic, output register and saturating counters.
// TESTING
//  1 mode=OFF, 300 random symbols with valid_i=1 -> sym_o==sym_i one cycle later; err_sym_ct=0, sym_ct=300.
//  2 BURST, start=27, len=4, mask=2'b01, limit=256, 300 symbols -> only idx%32 in 27..30 and idx<256 flipped in bit0; err_sym_ct=32, bad_bit_ct=32, active_o=0 after 256.
//  3 BURST, start=30, len=4, mask=2'b11 -> phases 30,31,0,1 hit (wrap); 64 symbols give err_sym_ct=8, bad_bit_ct=16.
//  4 RANDOM, thresh=0 then thresh=all-ones, 100 symbols each -> 0 hits then 100 hits; BOTH with burst len=0 matches RANDOM sequence exactly.
//  5 valid_i toggled 1,0,1,0 in BURST start=0 len=1 -> only symbols 0,32,64 hit; valid_o mirrors valid_i delayed 1; sym_o held during gaps.
//  6 clear_i with valid_i mid-burst -> that symbol clean, counters 0; CNT_W=4 run of 20 hits saturates err_sym_ct at 15; rst mid-stream gives valid_o=0 next cycle.

Source files
------------

// File: rtl/chan_err_pkg.sv
// Shared types, constants and helpers for the channel error injector.
package chan_err_pkg;

    // Corruption source selection.
    typedef enum logic [1:0] {
        ERR_OFF    = 2'd0,
        ERR_BURST  = 2'd1,
        ERR_RANDOM = 2'd2,
        ERR_BOTH   = 2'd3
    } err_mode_e;

    localparam int unsigned POPCNT_IN_W  = 32;
    localparam int unsigned POPCNT_OUT_W = 6;

    // Maximal-length Galois taps for a 16-bit right-shifting LFSR.
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

    // Number of set bits in a word of up to 32 bits.
    function automatic logic [POPCNT_OUT_W-1:0] popcount(input logic [POPCNT_IN_W-1:0] v);
        logic [POPCNT_OUT_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(POPCNT_IN_W); i++) begin
            c = c + POPCNT_OUT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/chan_err_injector_lfsr_gen.sv
// Galois LFSR used as the random-error source; never leaves the nonzero cycle.
module lfsr_gen
    import chan_err_pkg::*;
#(
    parameter int unsigned     W    = 16,
    parameter logic [W-1:0]    SEED = W'(16'hACE1),
    parameter logic [W-1:0]    TAPS = W'(LFSR_TAPS_16)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         step,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // Reseed on clear, otherwise shift right and fold taps when the LSB falls out.
    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = SEED;
        end else if (step) begin
            value_d = (value_q >> 1) ^ (value_q[0] ? TAPS : '0);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/chan_err_injector.sv
// Channel model: passes code symbols with one cycle of latency, XOR-corrupting
// selected symbols by burst window and/or LFSR draw, with saturating statistics.
module chan_err_injector
    import chan_err_pkg::*;
#(
    parameter int unsigned          SYM_W       = 2,
    parameter int unsigned          PERIOD_LOG2 = 5,
    parameter int unsigned          LFSR_W      = 16,
    parameter logic [LFSR_W-1:0]    LFSR_SEED   = LFSR_W'(16'hACE1),
    parameter logic [LFSR_W-1:0]    LFSR_TAPS   = LFSR_W'(LFSR_TAPS_16),
    parameter int unsigned          CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               cfg_mode_i,
    input  logic [PERIOD_LOG2-1:0]   cfg_burst_start_i,
    input  logic [PERIOD_LOG2:0]     cfg_burst_len_i,
    input  logic [SYM_W-1:0]         cfg_err_mask_i,
    input  logic [LFSR_W-1:0]        cfg_rand_thresh_i,
    input  logic [CNT_W-1:0]         cfg_sym_limit_i,
    input  logic                     clear_i,
    input  logic                     valid_i,
    input  logic [SYM_W-1:0]         sym_i,
    output logic                     valid_o,
    output logic [SYM_W-1:0]         sym_o,
    output logic                     err_o,
    output logic                     active_o,
    output logic [CNT_W-1:0]         sym_ct_o,
    output logic [CNT_W-1:0]         err_sym_ct_o,
    output logic [CNT_W-1:0]         bad_bit_ct_o
);

    logic [PERIOD_LOG2-1:0] sym_idx_q,  sym_idx_d;
    logic                   valid_q,    valid_d;
    logic [SYM_W-1:0]       sym_q,      sym_d;
    logic                   err_q,      err_d;
    logic [CNT_W-1:0]       sym_ct_q,   sym_ct_d;
    logic [CNT_W-1:0]       err_ct_q,   err_ct_d;
    logic [CNT_W-1:0]       bad_ct_q,   bad_ct_d;

    logic [LFSR_W-1:0]      lfsr_val;
    logic                   lfsr_step;
    logic                   lfsr_clear;

    logic [PERIOD_LOG2-1:0] phase_diff;
    logic                   burst_hit;
    logic                   rand_hit;
    logic                   active_c;
    logic                   hit_c;
    logic [CNT_W:0]         mask_pc;
    logic [CNT_W:0]         bad_sum;

    lfsr_gen #(
        .W    (LFSR_W),
        .SEED (LFSR_SEED),
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .clear (lfsr_clear),
        .step  (lfsr_step),
        .value (lfsr_val)
    );

    // Hit decision for the symbol presented this cycle; burst window wraps modulo the period.
    always_comb begin
        phase_diff = sym_idx_q - cfg_burst_start_i;
        burst_hit  = ({1'b0, phase_diff} < cfg_burst_len_i);
        rand_hit   = (lfsr_val <= cfg_rand_thresh_i);
        active_c   = (cfg_sym_limit_i == '0) || (sym_ct_q < cfg_sym_limit_i);
        hit_c      = 1'b0;
        case (err_mode_e'(cfg_mode_i))
            ERR_BURST:  hit_c = active_c & burst_hit;
            ERR_RANDOM: hit_c = active_c & rand_hit;
            ERR_BOTH:   hit_c = active_c & (burst_hit | rand_hit);
            default:    hit_c = 1'b0;
        endcase
        mask_pc = (CNT_W+1)'(popcount(POPCNT_IN_W'(cfg_err_mask_i)));
        bad_sum = {1'b0, bad_ct_q} + mask_pc;
    end

    // Next-state for index, output register and saturating statistics; clear wins over valid.
    always_comb begin
        sym_idx_d  = sym_idx_q;
        valid_d    = valid_i;
        sym_d      = sym_q;
        err_d      = err_q;
        sym_ct_d   = sym_ct_q;
        err_ct_d   = err_ct_q;
        bad_ct_d   = bad_ct_q;
        lfsr_step  = 1'b0;
        lfsr_clear = clear_i;
        if (clear_i) begin
            sym_idx_d = '0;
            sym_ct_d  = '0;
            err_ct_d  = '0;
            bad_ct_d  = '0;
            if (valid_i) begin
                sym_d = sym_i;
                err_d = 1'b0;
            end
        end else if (valid_i) begin
            sym_d     = sym_i ^ (hit_c ? cfg_err_mask_i : '0);
            err_d     = hit_c;
            sym_idx_d = sym_idx_q + PERIOD_LOG2'(1);
            lfsr_step = 1'b1;
            if (sym_ct_q != '1) begin
                sym_ct_d = sym_ct_q + CNT_W'(1);
            end
            if (hit_c) begin
                if (err_ct_q != '1) begin
                    err_ct_d = err_ct_q + CNT_W'(1);
                end
                bad_ct_d = bad_sum[CNT_W] ? '1 : bad_sum[CNT_W-1:0];
            end
        end
    end

    // Registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_idx_q <= '0;
            valid_q   <= 1'b0;
            sym_q     <= '0;
            err_q     <= 1'b0;
            sym_ct_q  <= '0;
            err_ct_q  <= '0;
            bad_ct_q  <= '0;
        end else begin
            sym_idx_q <= sym_idx_d;
            valid_q   <= valid_d;
            sym_q     <= sym_d;
            err_q     <= err_d;
            sym_ct_q  <= sym_ct_d;
            err_ct_q  <= err_ct_d;
            bad_ct_q  <= bad_ct_d;
        end
    end

    assign valid_o      = valid_q;
    assign sym_o        = sym_q;
    assign err_o        = err_q;
    assign active_o     = active_c;
    assign sym_ct_o     = sym_ct_q;
    assign err_sym_ct_o = err_ct_q;
    assign bad_bit_ct_o = bad_ct_q;

endmodule

// File: tb/tb_chan_err_injector.sv
// Directed bench for chan_err_injector with an independent reference model and scoreboard.
module tb_chan_err_injector;

    typedef struct packed {
        logic [1:0] sym;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [4:0]  st;
    logic [5:0]  blen;
    logic [1:0]  mask;
    logic [15:0] thr;
    logic [15:0] lim;
    logic [3:0]  lim2;
    logic        clear_i;
    logic        valid_i;
    logic [1:0]  sym_i;

    logic        valid_o, err_o, active_o;
    logic [1:0]  sym_o;
    logic [15:0] sym_ct_o, err_ct_o, bad_ct_o;

    logic        valid2, err2, active2;
    logic [1:0]  sym2;
    logic [3:0]  sym_ct2, err_ct2, bad_ct2;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    exp_t        sb_q[$];
    exp_t        last;
    int          m_idx, m_sym_ct, m_err_ct, m_bad_ct;
    logic [15:0] m_lfsr;
    int          rec_err;

    always #5 clk = ~clk;

    chan_err_injector dut (
        .clk(clk), .rst(rst), .cfg_mode_i(mode), .cfg_burst_start_i(st),
        .cfg_burst_len_i(blen), .cfg_err_mask_i(mask), .cfg_rand_thresh_i(thr),
        .cfg_sym_limit_i(lim), .clear_i(clear_i), .valid_i(valid_i), .sym_i(sym_i),
        .valid_o(valid_o), .sym_o(sym_o), .err_o(err_o), .active_o(active_o),
        .sym_ct_o(sym_ct_o), .err_sym_ct_o(err_ct_o), .bad_bit_ct_o(bad_ct_o)
    );

    chan_err_injector #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .cfg_mode_i(mode), .cfg_burst_start_i(st),
        .cfg_burst_len_i(blen), .cfg_err_mask_i(mask), .cfg_rand_thresh_i(thr),
        .cfg_sym_limit_i(lim2), .clear_i(clear_i), .valid_i(valid_i), .sym_i(sym_i),
        .valid_o(valid2), .sym_o(sym2), .err_o(err2), .active_o(active2),
        .sym_ct_o(sym_ct2), .err_sym_ct_o(err_ct2), .bad_bit_ct_o(bad_ct2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int sat16(input int x);
        return (x >= 65535) ? 65535 : x;
    endfunction

    task automatic model_reset();
        m_idx = 0; m_sym_ct = 0; m_err_ct = 0; m_bad_ct = 0;
        m_lfsr = 16'hACE1;
    endtask

    // One clock: predict, drive, then compare scoreboard head against DUT output.
    task automatic step(input logic v, input logic [1:0] s, input logic clr);
        logic hit, act, bh, rh;
        int   dd, pc;
        exp_t e;
        hit = 1'b0;
        pc  = int'(mask[0]) + int'(mask[1]);
        if (v && !clr) begin
            act = (lim == 16'd0) || (m_sym_ct < int'(lim));
            dd  = (((m_idx % 32) - int'(st)) % 32 + 32) % 32;
            bh  = (dd < int'(blen));
            rh  = (m_lfsr <= thr);
            case (mode)
                2'd1:    hit = act & bh;
                2'd2:    hit = act & rh;
                2'd3:    hit = act & (bh | rh);
                default: hit = 1'b0;
            endcase
        end
        if (v) begin
            e.sym = s ^ (hit ? mask : 2'b00);
            e.err = hit;
            sb_q.push_back(e);
        end
        valid_i = v; sym_i = s; clear_i = clr;
        @(posedge clk); #1;
        if (clr) begin
            model_reset();
        end else if (v) begin
            m_idx++;
            m_lfsr   = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
            m_sym_ct = sat16(m_sym_ct + 1);
            if (hit) begin
                m_err_ct = sat16(m_err_ct + 1);
                m_bad_ct = sat16(m_bad_ct + pc);
            end
        end
        chk("valid_o", valid_o, v);
        if (v) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("sym_o", sym_o, e.sym);
                chk("err_o", err_o, e.err);
                last = e;
            end
        end else begin
            chk("sym_hold", sym_o, last.sym);
            chk("err_hold", err_o, last.err);
        end
        valid_i = 1'b0; clear_i = 1'b0;
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_sym_ct"}, sym_ct_o, 32'(m_sym_ct));
        chk({tag, "_err_ct"}, err_ct_o, 32'(m_err_ct));
        chk({tag, "_bad_ct"}, bad_ct_o, 32'(m_bad_ct));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0);
    endtask

    task automatic do_clear();
        step(1'b0, 2'b00, 1'b1);
    endtask

    initial begin
        rst = 1'b1; mode = 2'd0; st = '0; blen = '0; mask = '0; thr = '0; lim = '0; lim2 = '0;
        clear_i = 1'b0; valid_i = 1'b0; sym_i = '0;
        last = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_o", valid_o, 0);
        chk("rst_sym_o", sym_o, 0);
        chk("rst_err_o", err_o, 0);
        chk("rst_active_o", active_o, 1);
        chk_stats("rst");
        rst = 1'b0;

        // 1: pass-through
        mode = 2'd0;
        run(300);
        chk_stats("t1");
        chk("t1_sym_ct_300", sym_ct_o, 300);
        chk("t1_err_0", err_ct_o, 0);

        // 2: burst with symbol limit
        do_clear();
        mode = 2'd1; st = 5'd27; blen = 6'd4; mask = 2'b01; lim = 16'd256;
        run(300);
        chk_stats("t2");
        chk("t2_err_32", err_ct_o, 32);
        chk("t2_bad_32", bad_ct_o, 32);
        chk("t2_active_0", active_o, 0);
        lim = 16'd0;
        #1;
        chk("t2_active_reopen", active_o, 1);

        // 3: burst window wrapping the period boundary
        do_clear();
        st = 5'd30; blen = 6'd4; mask = 2'b11; lim = 16'd0;
        run(64);
        chk_stats("t3");
        chk("t3_err_8", err_ct_o, 8);
        chk("t3_bad_16", bad_ct_o, 16);

        // 4: random threshold extremes, then BOTH with empty burst mirrors RANDOM
        do_clear();
        mode = 2'd2; thr = 16'h0000; mask = 2'b10;
        run(100);
        chk("t4_never", err_ct_o, 0);
        do_clear();
        thr = 16'hFFFF;
        run(100);
        chk("t4_always", err_ct_o, 100);
        do_clear();
        thr = 16'h3000;
        run(100);
        chk_stats("t4_rand");
        rec_err = m_err_ct;
        do_clear();
        mode = 2'd3; blen = 6'd0;
        run(100);
        chk_stats("t4_both");
        chk("t4_both_eq_rand", err_ct_o, 32'(rec_err));

        // 5: gapped valid, single-symbol burst at phase 0
        do_clear();
        mode = 2'd1; st = 5'd0; blen = 6'd1; mask = 2'b11;
        for (int i = 0; i < 130; i++) step(i[0] ? 1'b0 : 1'b1, 2'($urandom_range(0, 3)), 1'b0);
        chk_stats("t5");
        chk("t5_err_3", err_ct_o, 3);
        chk("t5_sym_65", sym_ct_o, 65);

        // 6: clear mid-burst, narrow-counter saturation, reset mid-stream
        do_clear();
        mode = 2'd1; st = 5'd0; blen = 6'd32; mask = 2'b01;
        run(5);
        chk("t6_pre_err", err_ct_o, 5);
        step(1'b1, 2'b10, 1'b1);
        chk_stats("t6_clear");
        chk("t6_clear_err_o", err_o, 0);
        run(20);
        chk_stats("t6_run");
        chk("t6_sat_err", err_ct2, 15);
        chk("t6_sat_sym", sym_ct2, 15);
        chk("t6_sat_bad", bad_ct2, 15);
        rst = 1'b1; valid_i = 1'b1; sym_i = 2'b11;
        @(posedge clk); #1;
        rst = 1'b0; valid_i = 1'b0;
        model_reset();
        last = '0;
        chk("t6_rst_valid_o", valid_o, 0);
        chk("t6_rst_sym_o", sym_o, 0);
        chk("t6_rst_active", active_o, 1);
        chk_stats("t6_rst");
        chk("t6_rst_err4", err_ct2, 0);
        run(3);
        chk_stats("t6_post");

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
